// File: rtl/mem_arbiter_rr.sv
// Shared single-port RAM arbiter: client 0 owns every PRIO_PERIOD-th slot, clients 1..N-1
// round-robin over the rest; read returns are broadcast and tagged by a one-hot valid.
module mem_arbiter_rr #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WBEN_W      = 4,
  parameter int unsigned PRIO_PERIOD = 2,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_wrdata,
  input  logic [NUM_CLIENTS*WBEN_W-1:0] req_op,
  input  logic [NUM_CLIENTS-1:0]        req_rts,
  output logic [NUM_CLIENTS-1:0]        req_rtr,
  output logic [WBEN_W-1:0]             mem_wben,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data_out,
  input  logic [DATA_W-1:0]             mem_data_in,
  output logic [DATA_W-1:0]             rd_data,
  output logic [NUM_CLIENTS-1:0]        rd_valid
);

  localparam int unsigned SLOT_W = (PRIO_PERIOD > 1) ? $clog2(PRIO_PERIOD) : 1;
  localparam int unsigned PTR_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned CW     = PTR_W + 1;
  localparam int unsigned DEPTH  = RD_LATENCY + 1;

  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [SLOT_W-1:0]      slot_cnt_q, slot_cnt_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WBEN_W-1:0]      mem_wben_q, mem_wben_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_data_out_q, mem_data_out_d;
  logic [NUM_CLIENTS-1:0] pipe_q [DEPTH];
  logic [NUM_CLIENTS-1:0] pipe_d [DEPTH];
  logic [NUM_CLIENTS-1:0] xfc_c;
  logic [CW-1:0]          cand;
  logic                   found;

  assign xfc_c = req_rts & grant_q;

  // Next grant: client 0 slot, then round-robin from rr_ptr, then idle-slot reuse by client 0
  always_comb begin
    grant_d    = '0;
    rr_ptr_d   = rr_ptr_q;
    found      = 1'b0;
    cand       = '0;
    slot_cnt_d = (slot_cnt_q == SLOT_W'(PRIO_PERIOD - 1)) ? '0 : slot_cnt_q + SLOT_W'(1);
    if (slot_cnt_q == '0 && req_rts[0]) begin
      grant_d[0] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_CLIENTS - 1; k++) begin
        cand = {1'b0, rr_ptr_q} + CW'(k);
        if (cand > CW'(NUM_CLIENTS - 1)) cand = cand - CW'(NUM_CLIENTS - 1);
        for (int j = 1; j < NUM_CLIENTS; j++) begin
          if (!found && req_rts[j] && cand == CW'(j)) begin
            found      = 1'b1;
            grant_d[j] = 1'b1;
            rr_ptr_d   = (j == NUM_CLIENTS - 1) ? PTR_W'(1) : PTR_W'(j + 1);
          end
        end
      end
      if (!found && req_rts[0]) grant_d[0] = 1'b1;
    end
  end

  // Capture the transferring client's payload; full writes carry no return tag
  always_comb begin
    mem_wben_d     = mem_wben_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    pipe_d[0]      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (xfc_c[i]) begin
        mem_wben_d     = req_op[i*WBEN_W +: WBEN_W];
        mem_addr_d     = req_addr[i*ADDR_W +: ADDR_W];
        mem_data_out_d = req_wrdata[i*DATA_W +: DATA_W];
        if (req_op[i*WBEN_W +: WBEN_W] != '1) pipe_d[0][i] = 1'b1;
      end
    end
    for (int s = 1; s < DEPTH; s++) pipe_d[s] = pipe_q[s-1];
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      grant_q        <= '0;
      slot_cnt_q     <= '0;
      rr_ptr_q       <= PTR_W'(1);
      mem_wben_q     <= '0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      for (int s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
    end else begin
      grant_q        <= grant_d;
      slot_cnt_q     <= slot_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      mem_wben_q     <= mem_wben_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      for (int s = 0; s < DEPTH; s++) pipe_q[s] <= pipe_d[s];
    end
  end

  assign req_rtr      = grant_q;
  assign mem_wben     = mem_wben_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;
  assign rd_valid     = pipe_q[DEPTH-1];
  assign rd_data      = mem_data_in;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios plus random traffic against a
// transaction-level reference of the arbitration and return rules.
module tb_mem_arbiter_rr;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 17;
  localparam int unsigned DW  = 32;
  localparam int unsigned WW  = 4;
  localparam int unsigned P   = 2;
  localparam int unsigned LAT = 2;

  logic          clk;
  logic          rst_;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wrdata;
  logic [N*WW-1:0] req_op;
  logic [N-1:0]  req_rts;
  logic [N-1:0]  req_rtr;
  logic [WW-1:0] mem_wben;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] rd_data;
  logic [N-1:0]  rd_valid;

  mem_arbiter_rr #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .WBEN_W(WW),
    .PRIO_PERIOD(P), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_(rst_),
    .req_addr(req_addr), .req_wrdata(req_wrdata), .req_op(req_op),
    .req_rts(req_rts), .req_rtr(req_rtr),
    .mem_wben(mem_wben), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference state: whole-cycle view of who holds the slot and what has been issued
  int            m_slot, m_ptr, m_grant, m_xfc, e_cnt;
  logic [WW-1:0] m_wben;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  exp_valid [int];

  int seq3 [6] = '{1, 2, 3, 1, 2, 3};
  int seq4 [6] = '{0, 1, 0, 2, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] oh(input int g);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  // Requesting client 1..N-1 closest at or after the pointer, counting cyclically
  function automatic int rr_pick(input logic [N-1:0] rts, input int ptr);
    int best  = -1;
    int bestd = N;
    int nr    = N - 1;
    for (int j = 1; j < N; j++) begin
      int d = (j - ptr + nr) % nr;
      if (rts[j] && d < bestd) begin
        best  = j;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_slot  = 0;
    m_ptr   = 1;
    m_grant = -1;
    m_xfc   = -1;
    m_wben  = '0;
    m_addr  = '0;
    m_data  = '0;
    exp_valid.delete();
  endtask

  task automatic model_edge();
    int x = -1;
    int r;
    if (m_grant >= 0 && req_rts[m_grant]) x = m_grant;
    e_cnt++;
    m_xfc = x;
    if (x >= 0) begin
      m_wben = req_op[x*WW +: WW];
      m_addr = req_addr[x*AW +: AW];
      m_data = req_wrdata[x*DW +: DW];
      if (m_wben != {WW{1'b1}}) exp_valid[e_cnt + int'(LAT)] = oh(x);
    end
    if (m_slot == 0 && req_rts[0]) begin
      m_grant = 0;
    end else begin
      r = rr_pick(req_rts, m_ptr);
      if (r >= 0) begin
        m_grant = r;
        m_ptr   = (r == N - 1) ? 1 : r + 1;
      end else if (req_rts[0]) begin
        m_grant = 0;
      end else begin
        m_grant = -1;
      end
    end
    m_slot = (m_slot + 1) % P;
  endtask

  task automatic chk_all();
    logic [N-1:0] exp_v;
    exp_v = exp_valid.exists(e_cnt) ? exp_valid[e_cnt] : '0;
    chk("req_rtr", req_rtr, oh(m_grant));
    chk("mem_wben", mem_wben, m_wben);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_data_out", mem_data_out, m_data);
    chk("rd_valid", rd_valid, exp_v);
    chk("rd_data", rd_data, mem_data_in);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_) model_edge();
    #1;
    chk_all();
    mem_data_in = $urandom;
  endtask

  task automatic set_client(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [WW-1:0] op);
    req_addr[i*AW +: AW]   = a;
    req_wrdata[i*DW +: DW] = d;
    req_op[i*WW +: WW]     = op;
  endtask

  task automatic do_reset(input int n);
    rst_ = 1'b0;
    model_reset();
    repeat (n) step();
    rst_ = 1'b1;
  endtask

  task automatic rand_drive();
    logic [WW-1:0] op;
    for (int i = 0; i < N; i++) begin
      if (m_xfc == i) begin
        req_rts[i] = 1'b0;
      end else if (req_rts[i]) begin
        if ($urandom_range(0, 39) == 0) req_rts[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       op = '0;
          1:       op = '1;
          default: op = WW'($urandom);
        endcase
        set_client(i, AW'($urandom), $urandom, op);
        req_rts[i] = 1'b1;
      end
    end
  endtask

  initial begin
    rst_        = 1'b0;
    req_rts     = '0;
    req_addr    = '0;
    req_wrdata  = '0;
    req_op      = '0;
    mem_data_in = '0;
    e_cnt       = 0;
    model_reset();

    // Reset held with random inputs, then idle release
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) set_client(i, AW'($urandom), $urandom, WW'($urandom));
      req_rts = N'($urandom);
      step();
      chk("rst_ctl", {req_rtr, mem_wben, rd_valid}, '0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_data", mem_data_out, '0);
    end
    req_rts = '0;
    rst_    = 1'b1;
    repeat (3) begin
      step();
      chk("idle_rtr", req_rtr, '0);
    end

    // Single read from client 2
    set_client(2, 17'h00123, $urandom, 4'h0);
    req_rts = 4'b0100;
    step();
    chk("t2_rtr", req_rtr, 4'b0100);
    step();
    chk("t2_addr", mem_addr, 17'h00123);
    chk("t2_wben", mem_wben, 4'h0);
    req_rts = '0;
    step();
    chk("t2_valid_early", rd_valid, 4'b0000);
    step();
    chk("t2_valid", rd_valid, 4'b0100);
    chk("t2_rd_data", rd_data, mem_data_in);
    step();
    chk("t2_valid_after", rd_valid, 4'b0000);
    repeat (2) step();

    // Round-robin among 1..3
    do_reset(2);
    for (int i = 1; i < N; i++) set_client(i, AW'($urandom), $urandom, 4'h0);
    req_rts = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_grant", req_rtr, oh(seq3[k]));
    end
    req_rts = '0;
    repeat (5) step();

    // Client 0 guaranteed slot interleaved with round-robin
    do_reset(2);
    for (int i = 0; i < 3; i++) set_client(i, AW'($urandom), $urandom, 4'h0);
    req_rts = 4'b0111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t4_grant", req_rtr, oh(seq4[k]));
    end
    req_rts = '0;
    repeat (5) step();

    // Full write returns nothing; partial write returns
    do_reset(2);
    set_client(3, 17'h1FFFF, 32'hDEADBEEF, 4'hF);
    req_rts = 4'b1000;
    step();
    chk("t5_rtr", req_rtr, 4'b1000);
    step();
    chk("t5_wben", mem_wben, 4'hF);
    chk("t5_data", mem_data_out, 32'hDEADBEEF);
    chk("t5_addr", mem_addr, 17'h1FFFF);
    req_rts = '0;
    repeat (3) begin
      step();
      chk("t5_no_valid", rd_valid, 4'b0000);
    end
    set_client(3, 17'h1FFFF, 32'hDEADBEEF, 4'h3);
    req_rts = 4'b1000;
    step();
    step();
    chk("t5_pwben", mem_wben, 4'h3);
    req_rts = '0;
    step();
    step();
    chk("t5_pvalid", rd_valid, 4'b1000);
    repeat (2) step();

    // Reset with a read in flight
    do_reset(2);
    set_client(1, AW'($urandom), $urandom, 4'h0);
    req_rts = 4'b0001 << 1;
    step();
    chk("t6_rtr", req_rtr, 4'b0010);
    step();
    req_rts = '0;
    rst_    = 1'b0;
    model_reset();
    repeat (4) begin
      step();
      chk("t6_rst_valid", rd_valid, 4'b0000);
    end
    for (int i = 1; i < N; i++) set_client(i, AW'($urandom), $urandom, 4'h0);
    req_rts = 4'b1110;
    rst_    = 1'b1;
    step();
    chk("t6_first", req_rtr, 4'b0010);
    repeat (2) begin
      step();
      chk("t6_no_ghost", rd_valid, 4'b0000);
    end
    req_rts = '0;
    repeat (5) step();

    // Random traffic
    do_reset(2);
    repeat (600) begin
      step();
      rand_drive();
    end
    req_rts = '0;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
